// File: rtl/ss_drv.sv
// ============================================================================
// Module   : ss_drv
// Purpose  : Master-side SPI slave-select driver. Accepts a request that
//            carries a 4-bit target ID and drives the matching active-low
//            select. Around the shifter transfer it times the setup period
//            (select to xfer_start), the hold period (xfer_done to select
//            release) and a minimum gap before the next request is accepted.
// Ports    : clk, rst (async, active high)
//            req_i / req_id_i   - level request with target ID (valid < NUM_SS)
//            abort_i            - terminate the current transfer
//            xfer_done_i        - completion pulse from the shifter
//            req_ack_o          - pulse, request accepted
//            err_id_o           - pulse, request rejected (bad ID)
//            xfer_start_o       - pulse, start the shifter
//            ss_n_o             - active-low selects, at most one low
//            ss_id_o            - latched target ID
//            busy_o             - high when not idle
//            timeout_o          - pulse, ACTIVE watchdog fired
// Options  : SS_DRV_TIMEOUT_EN - enables the ACTIVE-state watchdog
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ss_drv #(
  parameter int NUM_SS      = 8,
  parameter int SETUP_CYC   = 2,
  parameter int HOLD_CYC    = 2,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [3:0]        req_id_i,
  input  logic              abort_i,
  input  logic              xfer_done_i,
  output logic              req_ack_o,
  output logic              err_id_o,
  output logic              xfer_start_o,
  output logic [NUM_SS-1:0] ss_n_o,
  output logic [2:0]        ss_id_o,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_SETUP  = 3'd1;
  localparam logic [2:0] c_ACTIVE = 3'd2;
  localparam logic [2:0] c_HOLD   = 3'd3;
  localparam logic [2:0] c_GAP    = 3'd4;

  localparam logic [15:0] c_SETUP_LD   = 16'(SETUP_CYC);
  localparam logic [15:0] c_HOLD_LD    = 16'(HOLD_CYC);
  localparam logic [15:0] c_GAP_LD     = 16'(GAP_CYC);
  localparam logic [15:0] c_TIMEOUT_LD = 16'(TIMEOUT_CYC);
  localparam logic [4:0]  c_NUM_SS     = 5'(NUM_SS);

  logic [2:0]        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              req_ack_q, req_ack_d;
  logic              err_id_q, err_id_d;
  logic              xfer_start_q, xfer_start_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;
  logic [2:0]        ss_id_q, ss_id_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;

  logic              w_id_ok;
  logic              w_accept;
  logic              w_cnt_exp;
  logic [NUM_SS-1:0] w_sel_n;

  // An ID with bit 3 set is always >= NUM_SS, so one compare covers both rules.
  assign w_id_ok   = {1'b0, req_id_i} < c_NUM_SS;
  assign w_accept  = (state_q == c_IDLE) && req_i && w_id_ok;
  // Counter is loaded with N and the state expires on the edge where it reads 1,
  // giving exactly N edges in the timed state.
  assign w_cnt_exp = (cnt_q == 16'd1);

  for (genvar gi = 0; gi < NUM_SS; gi++) begin : g_dec
    assign w_sel_n[gi] = (req_id_i[2:0] != 3'(gi));
  end

  // State register and shared down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_IDLE;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      c_IDLE: begin
        if (w_accept) begin
          state_d = c_SETUP;
          cnt_d   = c_SETUP_LD;
        end
      end
      c_SETUP: begin
        if (abort_i) begin
          state_d = c_GAP;
          cnt_d   = c_GAP_LD;
        end else if (w_cnt_exp) begin
          state_d = c_ACTIVE;
          // Harmless when the watchdog is disabled: ACTIVE ignores the count.
          cnt_d   = c_TIMEOUT_LD;
        end else begin
          cnt_d   = cnt_q - 16'd1;
        end
      end
      c_ACTIVE: begin
        // Abort takes priority over a simultaneous completion.
        if (abort_i) begin
          state_d = c_GAP;
          cnt_d   = c_GAP_LD;
        end else if (xfer_done_i) begin
          state_d = c_HOLD;
          cnt_d   = c_HOLD_LD;
        end
`ifdef SS_DRV_TIMEOUT_EN
        else if (w_cnt_exp) begin
          state_d = c_GAP;
          cnt_d   = c_GAP_LD;
        end else begin
          cnt_d   = cnt_q - 16'd1;
        end
`endif
      end
      c_HOLD: begin
        if (abort_i || w_cnt_exp) begin
          state_d = c_GAP;
          cnt_d   = c_GAP_LD;
        end else begin
          cnt_d   = cnt_q - 16'd1;
        end
      end
      c_GAP: begin
        if (w_cnt_exp) begin
          state_d = c_IDLE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d   = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = c_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Output next values; every output is registered below.
  always_comb begin
    req_ack_d    = w_accept;
    err_id_d     = (state_q == c_IDLE) && req_i && !w_id_ok;
    xfer_start_d = (state_q == c_SETUP) && !abort_i && w_cnt_exp;
    timeout_d    = 1'b0;
`ifdef SS_DRV_TIMEOUT_EN
    // Completion in the expiry cycle counts as done, not as a timeout.
    timeout_d    = (state_q == c_ACTIVE) && !abort_i && !xfer_done_i && w_cnt_exp;
`endif
    ss_id_d      = w_accept ? req_id_i[2:0] : ss_id_q;
    busy_d       = (state_d != c_IDLE);
    if (w_accept) begin
      ss_n_d = w_sel_n;
    end else if ((state_d == c_SETUP) || (state_d == c_ACTIVE) || (state_d == c_HOLD)) begin
      ss_n_d = ss_n_q;
    end else begin
      ss_n_d = '1;
    end
  end

  // Output registers; reset releases the selects asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ack_q    <= 1'b0;
      err_id_q     <= 1'b0;
      xfer_start_q <= 1'b0;
      ss_n_q       <= '1;
      ss_id_q      <= 3'd0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      req_ack_q    <= req_ack_d;
      err_id_q     <= err_id_d;
      xfer_start_q <= xfer_start_d;
      ss_n_q       <= ss_n_d;
      ss_id_q      <= ss_id_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
    end
  end

  assign req_ack_o    = req_ack_q;
  assign err_id_o     = err_id_q;
  assign xfer_start_o = xfer_start_q;
  assign ss_n_o       = ss_n_q;
  assign ss_id_o      = ss_id_q;
  assign busy_o       = busy_q;
  assign timeout_o    = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_ss_drv.sv
// ============================================================================
// Module   : tb_ss_drv
// Purpose  : Self-checking bench for ss_drv. A table of single-request
//            vectors from IDLE, followed by hand-written multi-cycle
//            sequences (full transfer timing, held request, aborts,
//            watchdog, reset in HOLD, reduced NUM_SS).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ss_drv;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [3:0] req_id;
  logic       abort;
  logic       xfer_done;

  logic       ack, err, xs, busy, tmo;
  logic [7:0] ss_n;
  logic [2:0] ss_id;

  logic       ack4, err4, xs4, busy4, tmo4;
  logic [3:0] ss_n4;
  logic [2:0] ss_id4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ss_drv #(
    .NUM_SS(8), .SETUP_CYC(2), .HOLD_CYC(2), .GAP_CYC(4), .TIMEOUT_CYC(16)
  ) u_dut (
    .clk(clk), .rst(rst), .req_i(req), .req_id_i(req_id), .abort_i(abort),
    .xfer_done_i(xfer_done), .req_ack_o(ack), .err_id_o(err),
    .xfer_start_o(xs), .ss_n_o(ss_n), .ss_id_o(ss_id), .busy_o(busy),
    .timeout_o(tmo)
  );

  ss_drv #(
    .NUM_SS(4), .SETUP_CYC(2), .HOLD_CYC(2), .GAP_CYC(4), .TIMEOUT_CYC(16)
  ) u_dut4 (
    .clk(clk), .rst(rst), .req_i(req), .req_id_i(req_id), .abort_i(abort),
    .xfer_done_i(xfer_done), .req_ack_o(ack4), .err_id_o(err4),
    .xfer_start_o(xs4), .ss_n_o(ss_n4), .ss_id_o(ss_id4), .busy_o(busy4),
    .timeout_o(tmo4)
  );

  typedef struct {
    logic [3:0] id;
    logic       ack;
    logic       err;
    logic [7:0] ss_n;
    logic [2:0] ss_id;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = 1'b0;
    req_id    = 4'd0;
    abort     = 1'b0;
    xfer_done = 1'b0;
    tick();
    tick();
    rst       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  cyc;
    bit  got, multi, saw;

    tbl[0]  = '{4'd0,  1'b1, 1'b0, 8'hFE, 3'd0};
    tbl[1]  = '{4'd1,  1'b1, 1'b0, 8'hFD, 3'd1};
    tbl[2]  = '{4'd2,  1'b1, 1'b0, 8'hFB, 3'd2};
    tbl[3]  = '{4'd3,  1'b1, 1'b0, 8'hF7, 3'd3};
    tbl[4]  = '{4'd4,  1'b1, 1'b0, 8'hEF, 3'd4};
    tbl[5]  = '{4'd5,  1'b1, 1'b0, 8'hDF, 3'd5};
    tbl[6]  = '{4'd6,  1'b1, 1'b0, 8'hBF, 3'd6};
    tbl[7]  = '{4'd7,  1'b1, 1'b0, 8'h7F, 3'd7};
    tbl[8]  = '{4'd8,  1'b0, 1'b1, 8'hFF, 3'd0};
    tbl[9]  = '{4'd9,  1'b0, 1'b1, 8'hFF, 3'd0};
    tbl[10] = '{4'd15, 1'b0, 1'b1, 8'hFF, 3'd0};

    // Reset state
    do_reset();
    check("rst_ss_n",  32'(ss_n), 32'hFF);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_ss_id", 32'(ss_id), 32'd0);
    check("rst_ack",   32'(ack), 32'd0);
    check("rst_xs",    32'(xs), 32'd0);
    check("rst_tmo",   32'(tmo), 32'd0);

    // Single request from IDLE, one vector per ID
    for (int i = 0; i < 11; i++) begin
      do_reset();
      req    = 1'b1;
      req_id = tbl[i].id;
      tick();
      req    = 1'b0;
      check($sformatf("tbl%0d_ack", i),   32'(ack),   32'(tbl[i].ack));
      check($sformatf("tbl%0d_err", i),   32'(err),   32'(tbl[i].err));
      check($sformatf("tbl%0d_ss_n", i),  32'(ss_n),  32'(tbl[i].ss_n));
      check($sformatf("tbl%0d_busy", i),  32'(busy),  32'(tbl[i].ack));
      check($sformatf("tbl%0d_ss_id", i), 32'(ss_id), 32'(tbl[i].ss_id));
    end

    // Full transfer timing: req id 5 at E, xfer_done at D = E+10
    do_reset();
    req = 1'b1; req_id = 4'd5;
    tick();                                  // E
    req = 1'b0;
    check("seq_ss_n_E", 32'(ss_n), 32'hDF);
    check("seq_ack_E",  32'(ack),  32'd1);
    tick();                                  // E+1
    check("seq_xs_E1",  32'(xs),   32'd0);
    check("seq_ack_E1", 32'(ack),  32'd0);
    tick();                                  // E+2
    check("seq_xs_E2",  32'(xs),   32'd1);
    repeat (7) tick();                       // E+9
    check("seq_xs_E9",  32'(xs),   32'd0);
    xfer_done = 1'b1;
    tick();                                  // D
    xfer_done = 1'b0;
    tick();                                  // D+1
    check("seq_hold_ss_n", 32'(ss_n), 32'hDF);
    tick();                                  // D+2
    check("seq_rel_ss_n",  32'(ss_n), 32'hFF);
    repeat (3) tick();                       // D+5
    check("seq_busy_D5",   32'(busy), 32'd1);
    tick();                                  // D+6
    check("seq_busy_D6",   32'(busy), 32'd0);

    // Held request: id 3 then 7, second ack on first IDLE cycle after GAP
    do_reset();
    req = 1'b1; req_id = 4'd3;
    tick();                                  // E
    check("held_ack1",  32'(ack),  32'd1);
    check("held_ss_n1", 32'(ss_n), 32'hF7);
    req_id = 4'd7;
    tick();
    tick();                                  // E+2
    check("held_xs",    32'(xs),   32'd1);
    check("held_noack", 32'(ack),  32'd0);
    xfer_done = 1'b1;
    tick();                                  // D
    xfer_done = 1'b0;
    cyc = 0; got = 1'b0; multi = 1'b0;
    while (!got && cyc < 20) begin
      tick();
      cyc++;
      if ($countones(~ss_n) > 1) multi = 1'b1;
      if (ack) got = 1'b1;
    end
    check("held_ack_lat", 32'(cyc),   32'd7);
    check("held_ss_n2",   32'(ss_n),  32'h7F);
    check("held_ss_id2",  32'(ss_id), 32'd7);
    check("held_onehot",  32'(multi), 32'd0);
    req = 1'b0;

    // Abort in SETUP at E+1
    do_reset();
    req = 1'b1; req_id = 4'd2;
    tick();                                  // E
    req = 1'b0; abort = 1'b1;
    tick();                                  // E+1
    abort = 1'b0;
    check("abs_ss_n", 32'(ss_n), 32'hFF);
    check("abs_busy", 32'(busy), 32'd1);
    saw = xs;
    repeat (3) begin
      tick();
      if (xs) saw = 1'b1;
    end                                      // E+4
    check("abs_busy_E4", 32'(busy), 32'd1);
    tick();                                  // E+5
    if (xs) saw = 1'b1;
    check("abs_busy_E5", 32'(busy), 32'd0);
    check("abs_no_xs",   32'(saw),  32'd0);

    // Abort together with xfer_done in ACTIVE: HOLD skipped
    do_reset();
    req = 1'b1; req_id = 4'd1;
    tick();                                  // E
    req = 1'b0;
    tick();
    tick();                                  // E+2, ACTIVE
    abort = 1'b1; xfer_done = 1'b1;
    tick();                                  // E+3
    abort = 1'b0; xfer_done = 1'b0;
    check("abd_ss_n", 32'(ss_n), 32'hFF);
    check("abd_busy", 32'(busy), 32'd1);
    repeat (3) tick();                       // E+6
    check("abd_busy_E6", 32'(busy), 32'd1);
    tick();                                  // E+7
    check("abd_busy_E7", 32'(busy), 32'd0);

    // Watchdog
    do_reset();
    req = 1'b1; req_id = 4'd0;
    tick();
    req = 1'b0;
    tick();
    tick();                                  // X: xfer_start
    check("wd_xs", 32'(xs), 32'd1);
`ifdef SS_DRV_TIMEOUT_EN
    repeat (15) tick();                      // X+15
    check("wd_tmo_X15",  32'(tmo),  32'd0);
    check("wd_ss_n_X15", 32'(ss_n), 32'hFE);
    tick();                                  // X+16
    check("wd_tmo_X16",  32'(tmo),  32'd1);
    check("wd_ss_n_X16", 32'(ss_n), 32'hFF);
    tick();
    check("wd_tmo_X17",  32'(tmo),  32'd0);
`else
    saw = 1'b0;
    repeat (40) begin
      tick();
      if (tmo) saw = 1'b1;
    end
    check("wd_no_tmo",  32'(saw),  32'd0);
    check("wd_ss_n",    32'(ss_n), 32'hFE);
    check("wd_busy",    32'(busy), 32'd1);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
`endif

    // Reset asserted in HOLD releases ss_n without a clock edge
    do_reset();
    req = 1'b1; req_id = 4'd4;
    tick();
    req = 1'b0;
    tick();
    tick();
    xfer_done = 1'b1;
    tick();                                  // HOLD
    xfer_done = 1'b0;
    check("rh_ss_n_hold", 32'(ss_n), 32'hEF);
    #2;
    rst = 1'b1;
    #1;
    check("rh_ss_n", 32'(ss_n), 32'hFF);
    check("rh_busy", 32'(busy), 32'd0);

    // NUM_SS = 4: id 6 is invalid, err_id repeats while req held
    do_reset();
    req = 1'b1; req_id = 4'd6;
    tick();
    check("n4_err",   32'(err4),  32'd1);
    check("n4_ack",   32'(ack4),  32'd0);
    check("n4_ss_n",  32'(ss_n4), 32'hF);
    check("n4_busy",  32'(busy4), 32'd0);
    tick();
    check("n4_err2",  32'(err4),  32'd1);
    req = 1'b0;
    tick();
    check("n4_err3",  32'(err4),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
